// File: rtl/clock_mode_ctrl.sv
// Mode/setting controller for a digital clock: debounced buttons, set/alarm FSM,
// idle timeout back to RUN, display blink and alarm ring control.
//
// state   | meaning
// S_RUN   | normal timekeeping, alarm may ring
// S_SET_H | editing current hour, seconds frozen
// S_SET_M | editing current minute, seconds frozen
// S_AL_H  | editing alarm hour
// S_AL_M  | editing alarm minute
module clock_mode_ctrl #(
    parameter int DB_CYC    = 200000,
    parameter int TIMEOUT_S = 10,
    parameter int RING_S    = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       alarm_en,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_minute,
    input  logic [5:0] cur_second,
    output logic [2:0] mode,
    output logic       hold,
    output logic       inc_hour,
    output logic       inc_min,
    output logic [5:0] alarm_hour,
    output logic [5:0] alarm_minute,
    output logic       alarm_ring,
    output logic       blink
);

    localparam logic [2:0] S_RUN   = 3'd0;
    localparam logic [2:0] S_SET_H = 3'd1;
    localparam logic [2:0] S_SET_M = 3'd2;
    localparam logic [2:0] S_AL_H  = 3'd3;
    localparam logic [2:0] S_AL_M  = 3'd4;

    localparam int DB_CW  = $clog2(DB_CYC);
    localparam int IDLE_W = $clog2(TIMEOUT_S + 1);
    localparam int RING_W = $clog2(RING_S + 1);

    // bit 0 = mode button, bit 1 = inc button
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            db_q, db_d;
    logic [1:0][DB_CW-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]            ev_q, ev_d;

    logic [2:0]        mode_q, mode_d;
    logic              hold_q, hold_d;
    logic              inc_hour_q, inc_hour_d;
    logic              inc_min_q, inc_min_d;
    logic [5:0]        alarm_hour_q, alarm_hour_d;
    logic [5:0]        alarm_minute_q, alarm_minute_d;
    logic              ring_q, ring_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              blink_q, blink_d;

    logic ev_mode, ev_inc, any_ev, match;

    always_comb begin
        sync1_d  = {btn_inc, btn_mode};
        sync2_d  = sync1_q;
        db_d     = db_q;
        db_cnt_d = '0;
        ev_d     = '0;
        // Any sample agreeing with the debounced level leaves the counter at zero
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_CW'(DB_CYC - 1)) begin
                    db_d[i] = sync2_q[i];
                    ev_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        ev_mode = ev_q[0];
        ev_inc  = ev_q[1];
        any_ev  = |ev_q;
        match   = (mode_q == S_RUN) && alarm_en && (cur_hour == alarm_hour_q) &&
                  (cur_minute == alarm_minute_q) && (cur_second == 6'd0) && tick_1hz;

        mode_d         = mode_q;
        inc_hour_d     = 1'b0;
        inc_min_d      = 1'b0;
        alarm_hour_d   = alarm_hour_q;
        alarm_minute_d = alarm_minute_q;
        ring_d         = ring_q;
        ring_cnt_d     = ring_cnt_q;
        idle_d         = idle_q;
        blink_d        = blink_q;

        if (ring_q) begin
            if (any_ev || !alarm_en || (mode_q != S_RUN)) begin
                ring_d     = 1'b0;
                ring_cnt_d = '0;
            end else if (tick_1hz) begin
                if (ring_cnt_q == RING_W'(RING_S - 1)) begin
                    ring_d     = 1'b0;
                    ring_cnt_d = '0;
                end else begin
                    ring_cnt_d = ring_cnt_q + 1'b1;
                end
            end
        end else if (match) begin
            ring_d     = 1'b1;
            ring_cnt_d = '0;
        end

        // A press that silences the alarm is swallowed; timeout beats a coincident press
        if (ring_q) begin
            mode_d = mode_q;
        end else if ((mode_q != S_RUN) && (idle_q == IDLE_W'(TIMEOUT_S))) begin
            mode_d = S_RUN;
        end else if (ev_mode) begin
            case (mode_q)
                S_RUN:   mode_d = S_SET_H;
                S_SET_H: mode_d = S_SET_M;
                S_SET_M: mode_d = S_AL_H;
                S_AL_H:  mode_d = S_AL_M;
                default: mode_d = S_RUN;
            endcase
        end else if (ev_inc) begin
            case (mode_q)
                S_SET_H: inc_hour_d = 1'b1;
                S_SET_M: inc_min_d  = 1'b1;
                S_AL_H:  alarm_hour_d   = (alarm_hour_q == 6'd23) ? 6'd0 : alarm_hour_q + 6'd1;
                S_AL_M:  alarm_minute_d = (alarm_minute_q == 6'd59) ? 6'd0 : alarm_minute_q + 6'd1;
                default: mode_d = mode_q;
            endcase
        end

        if ((mode_q == S_RUN) || (mode_d == S_RUN) || any_ev) begin
            idle_d = '0;
        end else if (tick_1hz) begin
            idle_d = idle_q + 1'b1;
        end

        if ((mode_d != mode_q) || (mode_q == S_RUN)) begin
            blink_d = 1'b0;
        end else if (tick_1hz) begin
            blink_d = ~blink_q;
        end

        hold_d = (mode_d == S_SET_H) || (mode_d == S_SET_M);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            db_q           <= '0;
            db_cnt_q       <= '0;
            ev_q           <= '0;
            mode_q         <= S_RUN;
            hold_q         <= 1'b0;
            inc_hour_q     <= 1'b0;
            inc_min_q      <= 1'b0;
            alarm_hour_q   <= '0;
            alarm_minute_q <= '0;
            ring_q         <= 1'b0;
            ring_cnt_q     <= '0;
            idle_q         <= '0;
            blink_q        <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            db_q           <= db_d;
            db_cnt_q       <= db_cnt_d;
            ev_q           <= ev_d;
            mode_q         <= mode_d;
            hold_q         <= hold_d;
            inc_hour_q     <= inc_hour_d;
            inc_min_q      <= inc_min_d;
            alarm_hour_q   <= alarm_hour_d;
            alarm_minute_q <= alarm_minute_d;
            ring_q         <= ring_d;
            ring_cnt_q     <= ring_cnt_d;
            idle_q         <= idle_d;
            blink_q        <= blink_d;
        end
    end

    assign mode         = mode_q;
    assign hold         = hold_q;
    assign inc_hour     = inc_hour_q;
    assign inc_min      = inc_min_q;
    assign alarm_hour   = alarm_hour_q;
    assign alarm_minute = alarm_minute_q;
    assign alarm_ring   = ring_q;
    assign blink        = blink_q;

endmodule
